// File: rtl/mem_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_if
//   Bundles every handshake and RAM-bus signal of mem_bus_arbiter.
//   master : arbiter view (takes requests and ram_rdata; drives ready, rdata
//            and the RAM control/address/write-data lines)
//   slave  : environment view (the IF/MEM requesters plus the RAM)
//   Signals:
//     inst_req/inst_addr -> inst_rdata/inst_ready        fetch port
//     data_req/data_we/data_addr/data_wdata
//                        -> data_rdata/data_ready        load/store port
//     ram_ce/ram_we/ram_addr/ram_wdata <- ram_rdata      single-ported RAM
// ---------------------------------------------------------------------------
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_ready;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_ready;

    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_we, data_addr, data_wdata,
        input  ram_rdata,
        output inst_rdata, inst_ready,
        output data_rdata, data_ready,
        output ram_ce, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_we, data_addr, data_wdata,
        output ram_rdata,
        input  inst_rdata, inst_ready,
        input  data_rdata, data_ready,
        input  ram_ce, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//   Shares one single-ported RAM between instruction fetch and load/store.
//   A request seen in IDLE is latched, held on the RAM for RAM_LATENCY BUSY
//   cycles, then completed in a RESP cycle with a one-cycle ready pulse.
//   Every access returns through IDLE, so back-to-back accesses cost
//   RAM_LATENCY+2 cycles.
//   Ports:
//     clk  - clock
//     rst  - synchronous reset, active-high
//     bus  - mem_bus_arbiter_if.master (requester handshakes + RAM bus)
//   Parameters: ADDR_W, DATA_W, RAM_LATENCY (1..4)
//   Build option: define MEM_ARB_ROUND_ROBIN_EN to alternate grants when both
//   requesters contend; otherwise data always wins over instruction.
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RAM_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    mem_bus_arbiter_if.master  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
    typedef enum logic {OWN_INST, OWN_DATA} owner_t;

    localparam int            CNT_W    = 3;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAM_LATENCY - 1);

    state_t            state_q;
    owner_t            owner_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ram_ce_q;
    logic              ram_we_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [DATA_W-1:0] ram_wdata_q;
    logic              inst_ready_q;
    logic              data_ready_q;
    logic [DATA_W-1:0] inst_rdata_q;
    logic [DATA_W-1:0] data_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    owner_t            last_grant_q;
`endif

    logic   grant_data_d;
    owner_t owner_d;

    // Grant decision, only consumed in IDLE when at least one request is up.
    always_comb begin
        grant_data_d = bus.data_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (bus.inst_req && bus.data_req) begin
            grant_data_d = (last_grant_q == OWN_INST);
        end
`endif
    end

    assign owner_d = grant_data_d ? OWN_DATA : OWN_INST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INST;
            cnt_q        <= '0;
            ram_ce_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            inst_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= OWN_INST;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.inst_req || bus.data_req) begin
                        state_q     <= ST_BUSY;
                        owner_q     <= owner_d;
                        cnt_q       <= '0;
                        ram_ce_q    <= 1'b1;
                        // Write strobe only for the first BUSY cycle of a store.
                        ram_we_q    <= grant_data_d && bus.data_we;
                        ram_addr_q  <= grant_data_d ? bus.data_addr : bus.inst_addr;
                        ram_wdata_q <= grant_data_d ? bus.data_wdata : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_grant_q <= owner_d;
`endif
                    end
                end
                ST_BUSY: begin
                    ram_we_q <= 1'b0;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= ST_RESP;
                        // Ready is registered so it is high exactly in RESP.
                        if (owner_q == OWN_DATA) begin
                            data_ready_q <= 1'b1;
                        end else begin
                            inst_ready_q <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    ram_ce_q     <= 1'b0;
                    inst_ready_q <= 1'b0;
                    data_ready_q <= 1'b0;
                    if (owner_q == OWN_DATA) begin
                        data_rdata_q <= bus.ram_rdata;
                    end else begin
                        inst_rdata_q <= bus.ram_rdata;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ram_ce     = ram_ce_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.inst_ready = inst_ready_q;
    assign bus.data_ready = data_ready_q;

    // During RESP the owner sees RAM data directly; otherwise the held copy.
    assign bus.inst_rdata = (state_q == ST_RESP && owner_q == OWN_INST) ? bus.ram_rdata
                                                                        : inst_rdata_q;
    assign bus.data_rdata = (state_q == ST_RESP && owner_q == OWN_DATA) ? bus.ram_rdata
                                                                        : data_rdata_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
//   Testbench for mem_bus_arbiter: RAM model with configurable read latency,
//   a per-cycle reference model expressed as elapsed cycles since grant,
//   a vector table of single/dual accesses, directed corner sequences and a
//   randomized phase with occasional resets.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;
    parameter int LAT = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic init_mem;
    always #5 clk = ~clk;

    mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_bus_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .RAM_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i == 16) ? 32'h2408_0005 : (32'h1000_0000 | 32'(i));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ---------------- RAM model: data valid LAT cycles after address ----------
    logic [31:0] ram [256];
    logic        st_ce   [LAT];
    logic [31:0] st_addr [LAT];
    logic [31:0] junk;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int unsigned i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else if (bus.ram_ce && bus.ram_we) begin
            ram[bus.ram_addr[9:2]] <= bus.ram_wdata;
        end
        st_ce[0]   <= bus.ram_ce;
        st_addr[0] <= bus.ram_addr;
        for (int i = 1; i < LAT; i++) begin
            st_ce[i]   <= st_ce[i-1];
            st_addr[i] <= st_addr[i-1];
        end
        junk <= $urandom;
    end

    assign bus.ram_rdata = st_ce[LAT-1] ? ram[st_addr[LAT-1][9:2]] : junk;

    // ---------------- Reference model, checked every cycle ---------------------
    bit          m_busy   = 1'b0;
    int          m_k      = 0;
    bit          m_data_own, m_store;
    logic [31:0] m_addr, m_wdata;
    logic [31:0] m_ihold  = '0;
    logic [31:0] m_dhold  = '0;
    bit          m_dvalid = 1'b1;
    logic [31:0] m_mem [256];
`ifdef MEM_ARB_ROUND_ROBIN_EN
    bit          m_last_data = 1'b0;
`endif

    always @(negedge clk) begin
        bit e_ce, e_we, e_ir, e_dr, pick;
        if (init_mem) begin
            for (int unsigned i = 0; i < 256; i++) m_mem[i] = init_word(i);
        end
        e_ce = m_busy;
        e_we = m_busy && (m_k == 1) && m_store;
        e_ir = m_busy && (m_k == LAT + 1) && !m_data_own;
        e_dr = m_busy && (m_k == LAT + 1) && m_data_own;
        chk("mon ram_ce",     32'(bus.ram_ce),     32'(e_ce));
        chk("mon ram_we",     32'(bus.ram_we),     32'(e_we));
        chk("mon inst_ready", 32'(bus.inst_ready), 32'(e_ir));
        chk("mon data_ready", 32'(bus.data_ready), 32'(e_dr));
        if (e_ce) chk("mon ram_addr", bus.ram_addr, m_addr);
        if (e_we) chk("mon ram_wdata", bus.ram_wdata, m_wdata);
        if (e_ir) m_ihold = m_mem[m_addr[9:2]];
        if (e_dr) begin
            if (m_store) m_dvalid = 1'b0;
            else begin
                m_dhold  = m_mem[m_addr[9:2]];
                m_dvalid = 1'b1;
            end
        end
        chk("mon inst_rdata", bus.inst_rdata, m_ihold);
        if (m_dvalid) chk("mon data_rdata", bus.data_rdata, m_dhold);
        if (e_we) m_mem[m_addr[9:2]] = m_wdata;

        if (rst) begin
            m_busy   = 1'b0;
            m_ihold  = '0;
            m_dhold  = '0;
            m_dvalid = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            m_last_data = 1'b0;
`endif
        end else if (m_busy) begin
            if (m_k == LAT + 1) m_busy = 1'b0;
            else m_k++;
        end else if (bus.inst_req || bus.data_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            pick = bus.data_req && (!bus.inst_req || !m_last_data);
            m_last_data = pick;
`else
            pick = bus.data_req;
`endif
            m_busy     = 1'b1;
            m_k        = 1;
            m_data_own = pick;
            m_store    = pick && bus.data_we;
            m_addr     = pick ? bus.data_addr : bus.inst_addr;
            m_wdata    = bus.data_wdata;
        end
    end

    // ---------------- Helpers ---------------------------------------------------
    task automatic chk_reset_outputs(input string tag);
        chk({tag, " ram_ce"},     32'(bus.ram_ce),     32'h0);
        chk({tag, " ram_we"},     32'(bus.ram_we),     32'h0);
        chk({tag, " ram_addr"},   bus.ram_addr,        32'h0);
        chk({tag, " ram_wdata"},  bus.ram_wdata,       32'h0);
        chk({tag, " inst_ready"}, 32'(bus.inst_ready), 32'h0);
        chk({tag, " data_ready"}, 32'(bus.data_ready), 32'h0);
        chk({tag, " inst_rdata"}, bus.inst_rdata,      32'h0);
        chk({tag, " data_rdata"}, bus.data_rdata,      32'h0);
    endtask

    // Starts at a drive point with the DUT in IDLE; returns cycle of each ready
    // (relative to the request cycle, -1 if never seen) and the rdata seen then.
    task automatic run_access(input bit ireq, input bit dreq, input bit dwe,
                              input logic [31:0] iaddr, input logic [31:0] daddr,
                              input logic [31:0] wdata,
                              output int icyc, output int dcyc,
                              output logic [31:0] ird, output logic [31:0] drd);
        bit ipend, dpend;
        icyc = -1; dcyc = -1; ird = '0; drd = '0;
        bus.inst_req = ireq; bus.inst_addr = iaddr;
        bus.data_req = dreq; bus.data_we = dwe;
        bus.data_addr = daddr; bus.data_wdata = wdata;
        ipend = ireq; dpend = dreq;
        for (int c = 0; c < 8 * (LAT + 2) && (ipend || dpend); c++) begin
            @(negedge clk);
            if (bus.inst_ready) begin icyc = c; ird = bus.inst_rdata; end
            if (bus.data_ready) begin dcyc = c; drd = bus.data_rdata; end
            next_cycle();
            if (icyc == c) begin bus.inst_req = 1'b0; ipend = 1'b0; end
            if (dcyc == c) begin bus.data_req = 1'b0; dpend = 1'b0; end
        end
        bus.inst_req = 1'b0;
        bus.data_req = 1'b0;
    endtask

    typedef struct {
        bit          ireq, dreq, dwe;
        logic [31:0] iaddr, daddr, wdata, exp_i, exp_d;
    } vec_t;

    vec_t vt [8];

    initial begin
        int          icyc, dcyc, nr, rc;
        logic [31:0] ird, drd;
        bit          got, ia, da, iseen, dseen;
        int          rcyc [4];
        bit          rdat [4];

        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,         32'h0,         32'h2408_0005, 32'h0};
        vt[1] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0000, 32'h0,         32'h0,         32'h1000_0000};
        vt[2] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0000_0100, 32'hDEAD_BEEF, 32'h0,         32'h0};
        vt[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0100, 32'h0,         32'h0,         32'hDEAD_BEEF};
        vt[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_03FC, 32'h0,         32'h0,         32'h1000_00FF, 32'h0};
        vt[5] = '{1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0000_0200, 32'h0,         32'h1000_0011, 32'h1000_0080};
        vt[6] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,         32'h0};
        vt[7] = '{1'b1, 1'b0, 1'b0, 32'h0000_03FC, 32'h0,         32'h0,         32'hFFFF_FFFF, 32'h0};

        init_mem = 1'b1; rst = 1'b1;
        bus.inst_req = 1'b0; bus.inst_addr = '0;
        bus.data_req = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_wdata = '0;
        repeat (3) next_cycle();
        init_mem = 1'b0;
        @(negedge clk);
        chk_reset_outputs("reset");
        next_cycle();
        rst = 1'b0;

        // ---- vector table ----
        for (int v = 0; v < 8; v++) begin
            run_access(vt[v].ireq, vt[v].dreq, vt[v].dwe, vt[v].iaddr, vt[v].daddr,
                       vt[v].wdata, icyc, dcyc, ird, drd);
            if (vt[v].dreq) begin
                chk($sformatf("vec%0d data_ready cycle", v), 32'(dcyc), 32'(LAT + 1));
                if (!vt[v].dwe) chk($sformatf("vec%0d data_rdata", v), drd, vt[v].exp_d);
            end
            if (vt[v].ireq) begin
                chk($sformatf("vec%0d inst_ready cycle", v), 32'(icyc),
                    vt[v].dreq ? 32'(2 * LAT + 3) : 32'(LAT + 1));
                chk($sformatf("vec%0d inst_rdata", v), ird, vt[v].exp_i);
            end
        end

        // ---- address changed after grant must not disturb the access ----
        bus.inst_req = 1'b1; bus.inst_addr = 32'h40;
        next_cycle();
        bus.inst_addr = 32'h80;
        got = 1'b0;
        for (int c = 1; c < 4 * (LAT + 2) && !got; c++) begin
            @(negedge clk);
            if (bus.ram_ce) chk("midbusy ram_addr", bus.ram_addr, 32'h40);
            if (bus.inst_ready) begin
                got = 1'b1;
                chk("midbusy ready cycle", 32'(c), 32'(LAT + 1));
                chk("midbusy inst_rdata", bus.inst_rdata, 32'h2408_0005);
            end
            next_cycle();
        end
        bus.inst_req = 1'b0;
        if (!got) chk("midbusy inst_ready seen", 32'h0, 32'h1);

        // ---- reset in the middle of a load ----
        rc = (LAT >= 2) ? 2 : 1;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h200;
        for (int c = 0; c < rc; c++) next_cycle();
        rst = 1'b1; bus.data_req = 1'b0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk_reset_outputs("midrst");
        next_cycle();
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            chk("midrst no data_ready", 32'(bus.data_ready), 32'h0);
            next_cycle();
        end
        run_access(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0, icyc, dcyc, ird, drd);
        chk("postrst inst_ready cycle", 32'(icyc), 32'(LAT + 1));
        chk("postrst inst_rdata", ird, 32'h1000_0011);

        // ---- both requests held for four accesses ----
        bus.inst_req = 1'b1; bus.inst_addr = 32'h40;
        bus.data_req = 1'b1; bus.data_we = 1'b0; bus.data_addr = 32'h200;
        nr = 0;
        for (int c = 0; c < 6 * (LAT + 2) && nr < 4; c++) begin
            @(negedge clk);
            if (bus.data_ready) begin rdat[nr] = 1'b1; rcyc[nr] = c; nr++; end
            else if (bus.inst_ready) begin rdat[nr] = 1'b0; rcyc[nr] = c; nr++; end
            next_cycle();
        end
        bus.inst_req = 1'b0; bus.data_req = 1'b0;
        chk("held completions", 32'(nr), 32'h4);
        for (int k = 0; k < nr; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            chk($sformatf("held grant%0d is data", k), 32'(rdat[k]), 32'((k % 2) == 0));
`else
            chk($sformatf("held grant%0d is data", k), 32'(rdat[k]), 32'h1);
`endif
            chk($sformatf("held ready%0d cycle", k), 32'(rcyc[k]), 32'(LAT + 1 + k * (LAT + 2)));
        end

        // ---- randomized traffic with occasional resets ----
        ia = 1'b0; da = 1'b0; iseen = 1'b0; dseen = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 249) == 0);
            if (ia && iseen) begin
                if ($urandom_range(0, 1) == 1) bus.inst_addr = $urandom;
                else begin bus.inst_req = 1'b0; ia = 1'b0; end
            end else if (!ia && $urandom_range(0, 2) == 0) begin
                ia = 1'b1; bus.inst_req = 1'b1; bus.inst_addr = $urandom;
            end
            if (da && dseen) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.data_addr = $urandom; bus.data_we = 1'($urandom_range(0, 1));
                    bus.data_wdata = $urandom;
                end else begin bus.data_req = 1'b0; da = 1'b0; end
            end else if (!da && $urandom_range(0, 2) == 0) begin
                da = 1'b1; bus.data_req = 1'b1; bus.data_addr = $urandom;
                bus.data_we = 1'($urandom_range(0, 1)); bus.data_wdata = $urandom;
            end
            @(negedge clk);
            iseen = bus.inst_ready;
            dseen = bus.data_ready;
            next_cycle();
        end
        rst = 1'b0; bus.inst_req = 1'b0; bus.data_req = 1'b0;
        repeat (2 * (LAT + 2)) next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
